// File: rtl/prog_mem.sv
// Program memory with a boot-time clear sweep, write-first synchronous read,
// and out-of-range read flagging. Addresses are checked at full bus width.
module prog_mem #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int DEPTH   = 32,
   parameter int INIT_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              ready,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err
);

   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BOOT_N = (DEPTH < 4) ? DEPTH : 4;
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   BOOT_W   = (ADDR_W+1)'(BOOT_N);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] clr_ptr_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              rd_err_q;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              wr_in_range;
   logic              rd_in_range;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] boot_word;
   logic [DATA_W-1:0] rd_word_d;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

   assign boot_word = ((INIT_EN != 0) && ({1'b0, clr_ptr_q} < BOOT_W))
                      ? DATA_W'(clr_ptr_q) + DATA_W'(1) : '0;

   // The clear sweep owns the write port; user writes only land once READY.
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = wr_addr[IDX_W-1:0];
      mem_wdata = wr_data;
      if (!reset) begin
         if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_widx  = clr_ptr_q[IDX_W-1:0];
            mem_wdata = boot_word;
         end else if (wr_en && wr_in_range) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   // Same-address write bypasses the array so the read sees the new word.
   assign rd_word_d = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR;
         clr_ptr_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else if (state_q == CLEAR) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         if (clr_ptr_q == LAST_PTR) begin
            state_q <= READY;
         end else begin
            clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
         end
      end else begin
         if (rd_req) begin
            rd_valid_q <= 1'b1;
            if (rd_in_range) begin
               rd_data_q <= rd_word_d;
               rd_err_q  <= 1'b0;
            end else begin
               rd_data_q <= '0;
               rd_err_q  <= 1'b1;
            end
         end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
         end
      end
   end

   assign ready    = (state_q == READY);
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the memory.
module tb_prog_mem;

   localparam int DEPTH = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic       ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_req;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_err;

   always #5 clk = ~clk;

   prog_mem #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .INIT_EN(1)) dut (
      .clk(clk), .reset(reset), .ready(ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: contents, readiness and expected outputs.
   logic [7:0] ref_mem [0:DEPTH-1];
   bit         ref_ready;
   int         ref_clear_cycles;
   logic [7:0] ref_data;
   logic       ref_valid;
   logic       ref_err;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst, input logic we, input logic [7:0] wa,
                             input logic [7:0] wd, input logic rq, input logic [7:0] ra);
      if (rst) begin
         ref_ready        = 1'b0;
         ref_clear_cycles = 0;
         ref_data         = 8'h00;
         ref_valid        = 1'b0;
         ref_err          = 1'b0;
      end else if (!ref_ready) begin
         ref_valid = 1'b0;
         ref_err   = 1'b0;
         ref_clear_cycles++;
         if (ref_clear_cycles == DEPTH) begin
            ref_ready = 1'b1;
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = (k < 4) ? 8'(k + 1) : 8'h00;
         end
      end else begin
         if (we && int'(wa) < DEPTH) ref_mem[wa] = wd;
         if (rq) begin
            ref_valid = 1'b1;
            if (int'(ra) < DEPTH) begin
               ref_data = ref_mem[ra];
               ref_err  = 1'b0;
            end else begin
               ref_data = 8'h00;
               ref_err  = 1'b1;
            end
            $display("rd addr=%0d data=%0h err=%0b", ra, ref_data, ref_err);
         end else begin
            ref_valid = 1'b0;
            ref_err   = 1'b0;
         end
      end
   endtask

   task automatic cycle(input logic rst, input logic we, input logic [7:0] wa,
                        input logic [7:0] wd, input logic rq, input logic [7:0] ra);
      reset   = rst;
      wr_en   = we;
      wr_addr = wa;
      wr_data = wd;
      rd_req  = rq;
      rd_addr = ra;
      @(posedge clk);
      model_edge(rst, we, wa, wd, rq, ra);
      #1;
      chk("ready",    {7'd0, ready},    {7'd0, ref_ready});
      chk("rd_valid", {7'd0, rd_valid}, {7'd0, ref_valid});
      chk("rd_err",   {7'd0, rd_err},   {7'd0, ref_err});
      chk("rd_data",  rd_data,          ref_data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a);
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      cycle(1'b0, 1'b1, a, d, 1'b0, 8'h00);
   endtask

   initial begin
      logic [7:0] wa;
      logic [7:0] ra;

      // Power-up reset, clear sweep, then boot pattern reads with gaps.
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      idle(DEPTH);
      for (int a = 0; a < 5; a++) begin
         rd(8'(a));
         idle(1);
      end

      // Back-to-back reads.
      for (int a = 0; a < 4; a++) rd(8'(a));
      idle(1);

      // Same-cycle write and read of one address.
      cycle(1'b0, 1'b1, 8'd7, 8'hA5, 1'b1, 8'd7);
      idle(1);

      // Out-of-range reads and a dropped out-of-range write.
      rd(8'd32);
      rd(8'd255);
      wr(8'd40, 8'h5A);
      rd(8'd8);
      idle(1);

      // Traffic during clear is ignored.
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      idle(10);
      cycle(1'b0, 1'b1, 8'd2, 8'hFF, 1'b1, 8'd2);
      idle(DEPTH - 11);
      rd(8'd2);
      idle(1);

      // Reset in READY, then again partway through the clear.
      wr(8'd0, 8'h77);
      rd(8'd0);
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      idle(5);
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
      idle(DEPTH);
      rd(8'd0);
      idle(1);

      // Random traffic with occasional resets and wild addresses.
      for (int i = 0; i < 400; i++) begin
         wa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 35));
         ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 35));
         if ($urandom_range(0, 3) == 0) ra = wa;
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), wa,
               8'($urandom), ($urandom_range(0, 1) == 1), ra);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 32, number of stored words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter INIT_EN, default 1; 1 = boot pattern loaded during clear, 0 = all-zero.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ready  output  1  memory accepts reads and writes.
REQ-008 SHALL have port wr_en  input  1  write strobe, single cycle per word.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port wr_data  input  DATA_W  write data.
REQ-011 SHALL have port rd_req  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR_W  read address (fetch pointer).
REQ-013 SHALL have port rd_data  output  DATA_W  registered instruction word.
REQ-014 SHALL have port rd_valid  output  1  rd_data/rd_err valid, one-cycle pulse per accepted read.
REQ-015 SHALL have port rd_err  output  1  accepted read addressed location >= DEPTH.

Function
REQ-016 SHALL implement a state machine with states CLEAR and READY; ready = (state == READY).
REQ-017 SHALL, in CLEAR, write one word per cycle at internal pointer clr_ptr = 0..DEPTH-1, then enter READY in the cycle after clr_ptr = DEPTH-1 is written (DEPTH cycles total).
REQ-018 SHALL, in CLEAR with INIT_EN=1, write value k+1 to address k for k < min(4, DEPTH) and 0 elsewhere; with INIT_EN=0 write 0 everywhere.
REQ-019 SHALL ignore wr_en and rd_req while in CLEAR: no array write, rd_valid = 0.
REQ-020 SHALL, in READY, write wr_data to wr_addr on a clock edge with wr_en=1 and wr_addr < DEPTH.
REQ-021 SHALL silently drop writes with wr_addr >= DEPTH (array unchanged, no error flag).
REQ-022 SHALL, in READY, accept a read every cycle rd_req=1: rd_valid=1 and rd_data registered exactly one cycle later (latency 1, throughput 1 word/cycle).
REQ-023 SHALL, for an accepted read with rd_addr >= DEPTH, return rd_data = 0 and rd_err = 1 with rd_valid = 1.
REQ-024 SHALL drive rd_err = 0 on every cycle rd_valid = 0 or the address was in range.
REQ-025 SHALL hold rd_data at its last value when no read is accepted; rd_valid SHALL drop to 0.
REQ-026 SHALL be write-first: a read and write to the same in-range address in the same cycle returns the new wr_data.
REQ-027 SHALL compare addresses at full ADDR_W width; no wrap-around or truncation modulo DEPTH.
REQ-028 SHALL not leave READY except by reset.

Reset
REQ-029 SHALL, on a clock edge with reset=1, enter CLEAR with clr_ptr = 0, ready = 0, rd_valid = 0, rd_err = 0, rd_data = 0.
REQ-030 SHALL, on reset asserted mid-CLEAR or in READY, restart the full clear sweep from address 0; stored contents are rewritten, not preserved.
REQ-031 SHALL hold all outputs at their reset values for every cycle reset remains 1.

Verification
REQ-032 Reset 1 cycle, defaults -> ready=0 for exactly 32 cycles, then ready=1; reads at 0..4 return 1,2,3,4,0 with rd_valid one cycle after each rd_req.
REQ-033 Back-to-back rd_req at addresses 0,1,2,3 on consecutive cycles -> rd_valid high 4 consecutive cycles, rd_data 1,2,3,4.
REQ-034 Write 0xA5 to address 7 and read address 7 in same cycle -> next cycle rd_data=0xA5, rd_valid=1, rd_err=0.
REQ-035 Read address 32 and 255 (DEPTH=32) -> rd_data=0, rd_err=1, rd_valid=1; write 0x5A to address 40 -> later read of address 8 returns 0.
REQ-036 rd_req and wr_en to address 2 (0xFF) at cycle 10 of CLEAR -> rd_valid stays 0; after ready, address 2 reads 3.
REQ-037 Write 0x77 to address 0 in READY, then reset for 1 cycle mid-operation, then reassert reset at clear cycle 5 -> ready rises 32 cycles after final reset; address 0 reads 1.
